// File: rtl/eth_link_sup_pkg.sv
// Shared types and constants for the 10G link supervisor.
package eth_link_sup_pkg;

   localparam int CNT_W = 16;

   typedef enum logic [2:0] {
      ST_WAIT_DONE  = 3'd0,
      ST_WAIT_LOCK  = 3'd1,
      ST_LINK_UP    = 3'd2,
      ST_ASSERT_RST = 3'd3
   } sup_state_e;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/eth_link_supervisor_if.sv
// PHY/GT-wizard status and control bundle seen by the link supervisor.
// master = PHY/wizard side, slave = supervisor side.
interface eth_link_supervisor_if;
   import eth_link_sup_pkg::*;

   logic             rx_block_lock;
   logic             rx_high_ber;
   logic             gt_reset_rx_done;
   logic             gtwiz_reset_rx_datapath;
   logic             link_up;
   logic [CNT_W-1:0] relock_count;
   logic [CNT_W-1:0] timeout_count;
   logic [2:0]       sup_state;

   modport master (
      output rx_block_lock, rx_high_ber, gt_reset_rx_done,
      input  gtwiz_reset_rx_datapath, link_up, relock_count, timeout_count, sup_state
   );

   modport slave (
      input  rx_block_lock, rx_high_ber, gt_reset_rx_done,
      output gtwiz_reset_rx_datapath, link_up, relock_count, timeout_count, sup_state
   );

endinterface

// File: rtl/eth_link_sync_bit.sv
// Two-flop synchronizer for a single asynchronous level into clk_125mhz_int.
module eth_link_sync_bit (
   input  logic clk_125mhz_int,
   input  logic gt_tx_reset,
   input  logic d_i,
   output logic q_o
);

   (* ASYNC_REG = "TRUE" *) logic meta_q;
   (* ASYNC_REG = "TRUE" *) logic sync_q;

   // Shift the async level through two flops; reset clears both to 0.
   always_ff @(posedge clk_125mhz_int or posedge gt_tx_reset) begin
      if (gt_tx_reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         // NOTE: non-blocking so sync_q takes the old meta_q; blocking would collapse the chain to one flop.
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/eth_link_supervisor.sv
// Link supervisor: decides link-up from synchronized PHY status and issues
// RX datapath reset requests with exponential backoff on lock timeouts.
module eth_link_supervisor
   import eth_link_sup_pkg::*;
#(
   parameter int LOCK_TIMEOUT_CYCLES = 125000,
   parameter int STABLE_CYCLES       = 1250,
   parameter int RESET_PULSE_CYCLES  = 16,
   parameter int MAX_BACKOFF_SHIFT   = 4
) (
   input  logic                  clk_125mhz_int,
   input  logic                  gt_tx_reset,
   eth_link_supervisor_if.slave  sup_if
);

   localparam int TMR_W = $clog2(LOCK_TIMEOUT_CYCLES << MAX_BACKOFF_SHIFT) + 1;
   localparam int BO_W  = (MAX_BACKOFF_SHIFT > 0) ? $clog2(MAX_BACKOFF_SHIFT + 1) : 1;
   localparam int STB_W = $clog2(STABLE_CYCLES) + 1;
   localparam int PLS_W = $clog2(RESET_PULSE_CYCLES + 1);

   localparam logic [TMR_W-1:0] TMR_BASE = TMR_W'(LOCK_TIMEOUT_CYCLES);
   localparam logic [BO_W-1:0]  BO_MAX   = BO_W'(MAX_BACKOFF_SHIFT);
   localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_CYCLES - 1);
   localparam logic [PLS_W-1:0] PLS_LEN  = PLS_W'(RESET_PULSE_CYCLES);

   logic lock_s, ber_s, done_s;
   logic status_good;

   sup_state_e       state_q;
   logic [TMR_W-1:0] timer_q;
   logic [STB_W-1:0] stable_q;
   logic [BO_W-1:0]  backoff_q;
   logic [PLS_W-1:0] pulse_q;
   logic             req_q;
   logic             link_q;
   logic [CNT_W-1:0] relock_cnt_q;
   logic [CNT_W-1:0] timeout_cnt_q;

   eth_link_sync_bit u_sync_lock (
      .clk_125mhz_int (clk_125mhz_int),
      .gt_tx_reset    (gt_tx_reset),
      .d_i            (sup_if.rx_block_lock),
      .q_o            (lock_s)
   );

   eth_link_sync_bit u_sync_ber (
      .clk_125mhz_int (clk_125mhz_int),
      .gt_tx_reset    (gt_tx_reset),
      .d_i            (sup_if.rx_high_ber),
      .q_o            (ber_s)
   );

   eth_link_sync_bit u_sync_done (
      .clk_125mhz_int (clk_125mhz_int),
      .gt_tx_reset    (gt_tx_reset),
      .d_i            (sup_if.gt_reset_rx_done),
      .q_o            (done_s)
   );

   assign status_good = lock_s & ~ber_s;

   // Supervisor FSM with its timer, stable counter, backoff and event counters.
   always_ff @(posedge clk_125mhz_int or posedge gt_tx_reset) begin
      if (gt_tx_reset) begin
         state_q       <= ST_WAIT_DONE;
         timer_q       <= '0;
         stable_q      <= '0;
         backoff_q     <= '0;
         pulse_q       <= '0;
         req_q         <= 1'b0;
         link_q        <= 1'b0;
         relock_cnt_q  <= '0;
         timeout_cnt_q <= '0;
      end else begin
         case (state_q)
            ST_WAIT_DONE: begin
               req_q  <= 1'b0;
               link_q <= 1'b0;
               if (done_s) begin
                  state_q  <= ST_WAIT_LOCK;
                  timer_q  <= TMR_BASE << backoff_q;
                  stable_q <= '0;
               end
            end

            ST_WAIT_LOCK: begin
               if (!done_s) begin
                  // Wizard is resetting on its own: just follow it.
                  state_q <= ST_WAIT_DONE;
               end else if (timer_q <= TMR_W'(1)) begin
                  // The decrement that would hit zero is the timeout, so the
                  // state dwells exactly the loaded number of cycles.
                  state_q       <= ST_ASSERT_RST;
                  timer_q       <= '0;
                  stable_q      <= '0;
                  pulse_q       <= '0;
                  timeout_cnt_q <= sat_inc(timeout_cnt_q);
                  backoff_q     <= (backoff_q >= BO_MAX) ? BO_MAX : backoff_q + 1'b1;
               end else begin
                  timer_q <= timer_q - 1'b1;
                  if (status_good && stable_q == STB_LAST) begin
                     state_q   <= ST_LINK_UP;
                     link_q    <= 1'b1;
                     backoff_q <= '0;
                  end else if (status_good) begin
                     stable_q <= stable_q + 1'b1;
                  end else begin
                     stable_q <= '0;
                  end
               end
            end

            ST_LINK_UP: begin
               if (!done_s) begin
                  state_q <= ST_WAIT_DONE;
                  link_q  <= 1'b0;
               end else if (!status_good) begin
                  state_q      <= ST_ASSERT_RST;
                  link_q       <= 1'b0;
                  pulse_q      <= '0;
                  relock_cnt_q <= sat_inc(relock_cnt_q);
               end
            end

            ST_ASSERT_RST: begin
               // Request rises one cycle after entry and holds for PLS_LEN cycles.
               if (pulse_q == PLS_LEN) begin
                  req_q   <= 1'b0;
                  state_q <= ST_WAIT_DONE;
               end else begin
                  req_q   <= 1'b1;
                  pulse_q <= pulse_q + 1'b1;
               end
            end

            default: begin
               state_q <= ST_WAIT_DONE;
               req_q   <= 1'b0;
               link_q  <= 1'b0;
            end
         endcase
      end
   end

   assign sup_if.gtwiz_reset_rx_datapath = req_q;
   assign sup_if.link_up                 = link_q;
   assign sup_if.relock_count            = relock_cnt_q;
   assign sup_if.timeout_count           = timeout_cnt_q;
   assign sup_if.sup_state               = state_q;

endmodule

// File: tb/tb_eth_link_supervisor.sv
// Self-checking bench for eth_link_supervisor with an event-level reference model.
module tb_eth_link_supervisor;
   import eth_link_sup_pkg::*;

   localparam int LT = 100;
   localparam int ST = 10;
   localparam int RP = 4;
   localparam int MB = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #4 clk = ~clk;

   eth_link_supervisor_if sif ();

   eth_link_supervisor #(
      .LOCK_TIMEOUT_CYCLES (LT),
      .STABLE_CYCLES       (ST),
      .RESET_PULSE_CYCLES  (RP),
      .MAX_BACKOFF_SHIFT   (MB)
   ) dut (
      .clk_125mhz_int (clk),
      .gt_tx_reset    (rst),
      .sup_if         (sif)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: counters and backoff derived from link events.
   int exp_relock = 0;
   int exp_tmo    = 0;
   int exp_bo     = 0;

   // Monitor observations: reset pulse widths and WAIT_LOCK dwell before a timeout.
   int pulse_w[$];
   int dwell[$];
   int req_run = 0;
   int wl_run  = 0;

   always @(negedge clk) begin
      if (sif.gtwiz_reset_rx_datapath === 1'b1) req_run++;
      else if (req_run != 0) begin
         pulse_w.push_back(req_run);
         req_run = 0;
      end
      if (sif.sup_state === 3'd1) wl_run++;
      else begin
         if (wl_run != 0 && sif.sup_state === 3'd3) dwell.push_back(wl_run);
         wl_run = 0;
      end
   end

   initial begin
      #(8 * 90000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic int exp_timeout();
      return LT << exp_bo;
   endfunction

   task automatic model_timeout();
      exp_tmo = (exp_tmo < 65535) ? exp_tmo + 1 : 65535;
      exp_bo  = (exp_bo < MB) ? exp_bo + 1 : MB;
   endtask

   task automatic model_loss();
      exp_relock = (exp_relock < 65535) ? exp_relock + 1 : 65535;
   endtask

   task automatic check_counts(input string tag);
      check({tag, "_relock"}, sif.relock_count, exp_relock);
      check({tag, "_tmo"}, sif.timeout_count, exp_tmo);
   endtask

   task automatic wait_for_state(input logic [2:0] s, input int budget, input string tag);
      int n = 0;
      while (sif.sup_state !== s && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(tag, sif.sup_state, s);
   endtask

   task automatic relink(input string tag);
      wait_for_state(3'd2, 80, {tag, "_relink"});
      check({tag, "_linkup"}, sif.link_up, 1'b1);
      exp_bo = 0;
   endtask

   // Bad status for `width` cycles from LINK_UP; lock stays low if hold is set.
   task automatic lose_link(input string tag, input bit by_ber, input int width, input bit hold);
      int n = 0;
      pulse_w.delete();
      dwell.delete();
      if (by_ber) sif.rx_high_ber = 1'b1;
      else        sif.rx_block_lock = 1'b0;
      while (sif.link_up === 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
         if (n == width) begin
            sif.rx_high_ber = 1'b0;
            if (!hold) sif.rx_block_lock = 1'b1;
         end
      end
      check({tag, "_fall"}, n, 3);
      model_loss();
      n = 0;
      while (pulse_w.size() == 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_npulse"}, pulse_w.size(), 1);
      if (pulse_w.size() > 0) check({tag, "_width"}, pulse_w[0], RP);
      check_counts(tag);
   endtask

   // Expect k consecutive lock timeouts with backoff-scaled dwell times.
   task automatic run_timeouts(input string tag, input int k);
      int n;
      pulse_w.delete();
      dwell.delete();
      for (int i = 0; i < k; i++) begin
         int e = exp_timeout();
         n = 0;
         while (dwell.size() <= i && n < e + 60) begin
            @(negedge clk);
            n++;
         end
         check($sformatf("%s_dwell%0d", tag, i), (dwell.size() > i) ? dwell[i] : 0, e);
         model_timeout();
      end
      n = 0;
      while (pulse_w.size() < k && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_npulse"}, pulse_w.size(), k);
      for (int i = 0; i < pulse_w.size(); i++)
         check($sformatf("%s_width%0d", tag, i), pulse_w[i], RP);
      check_counts(tag);
   endtask

   // Drop done while in WAIT_LOCK or LINK_UP: follow to WAIT_DONE, no side effects.
   task automatic self_reset(input string tag, input int hold_cycles);
      int n = 0;
      pulse_w.delete();
      sif.gt_reset_rx_done = 1'b0;
      while (sif.sup_state !== 3'd0 && n < 10) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_lat"}, n, 3);
      check({tag, "_link"}, sif.link_up, 1'b0);
      tick(hold_cycles);
      check({tag, "_hold_state"}, sif.sup_state, 3'd0);
      check({tag, "_nopulse"}, pulse_w.size(), 0);
      check({tag, "_req"}, sif.gtwiz_reset_rx_datapath, 1'b0);
      check_counts(tag);
      sif.gt_reset_rx_done = 1'b1;
   endtask

   initial begin
      int n;
      sif.rx_block_lock    = 1'b0;
      sif.rx_high_ber      = 1'b0;
      sif.gt_reset_rx_done = 1'b1;

      // Reset values, with done already asserted on the pin.
      tick(3);
      check("rst_req", sif.gtwiz_reset_rx_datapath, 1'b0);
      check("rst_link", sif.link_up, 1'b0);
      check("rst_state", sif.sup_state, 3'd0);
      check_counts("rst");
      rst = 1'b0;
      pulse_w.delete();
      dwell.delete();

      // Clean bring-up: link_up exactly ST+2 cycles after lock rises.
      wait_for_state(3'd1, 10, "bring_wl");
      tick($urandom_range(0, 30));
      sif.rx_block_lock = 1'b1;
      n = 0;
      while (sif.link_up !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("bring_lat", n, ST + 2);
      check("bring_state", sif.sup_state, 3'd2);
      check("bring_nopulse", pulse_w.size(), 0);
      exp_bo = 0;
      check_counts("bring");

      // Short lock drop and high-BER loss, each followed by automatic relock.
      lose_link("loss1", 1'b0, 1, 1'b0);
      relink("loss1");
      lose_link("ber", 1'b1, $urandom_range(1, 3), 1'b0);
      relink("ber");

      // Never lock: 100, 200, 400, 400 then relock.
      lose_link("hold", 1'b0, 1, 1'b1);
      run_timeouts("never", 4);
      sif.rx_block_lock = 1'b1;
      relink("never");

      // Backoff cleared by relock, then wizard self-reset keeps backoff.
      lose_link("hold2", 1'b0, 1, 1'b1);
      run_timeouts("clr", 1);
      wait_for_state(3'd1, 20, "self_wl");
      tick($urandom_range(1, 50));
      self_reset("self_wl", $urandom_range(1, 20));
      run_timeouts("after_self", 1);
      sif.rx_block_lock = 1'b1;
      relink("after_self");

      // Randomized sequence of link events.
      for (int it = 0; it < 8; it++) begin
         string tag = $sformatf("rnd%0d", it);
         case ($urandom_range(0, 3))
            0: begin
               lose_link(tag, 1'b0, $urandom_range(1, 3), 1'b0);
               relink(tag);
            end
            1: begin
               lose_link(tag, 1'b1, $urandom_range(1, 3), 1'b0);
               relink(tag);
            end
            2: begin
               lose_link(tag, 1'b0, 1, 1'b1);
               run_timeouts(tag, $urandom_range(1, 3));
               sif.rx_block_lock = 1'b1;
               relink(tag);
            end
            default: begin
               tick($urandom_range(0, 10));
               self_reset(tag, $urandom_range(1, 20));
               relink(tag);
            end
         endcase
      end

      // Saturation of relock_count.
      force dut.relock_cnt_q = 16'hFFFE;
      tick(1);
      release dut.relock_cnt_q;
      tick(1);
      exp_relock = 65534;
      check("sat_preload", sif.relock_count, exp_relock);
      lose_link("sat1", 1'b0, 1, 1'b0);
      relink("sat1");
      lose_link("sat2", 1'b0, 2, 1'b0);
      relink("sat2");
      check("sat_final", sif.relock_count, 16'hFFFF);

      // Async reset in the second cycle of a request pulse.
      sif.rx_block_lock = 1'b0;
      tick(1);
      sif.rx_block_lock = 1'b1;
      n = 0;
      while (sif.gtwiz_reset_rx_datapath !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("mid_req_seen", sif.gtwiz_reset_rx_datapath, 1'b1);
      tick(1);
      #2 rst = 1'b1;
      #1;
      check("mid_req", sif.gtwiz_reset_rx_datapath, 1'b0);
      check("mid_link", sif.link_up, 1'b0);
      check("mid_state", sif.sup_state, 3'd0);
      exp_relock = 0;
      exp_tmo    = 0;
      exp_bo     = 0;
      check_counts("mid");

      // First transition after reset release no earlier than 3 cycles.
      @(negedge clk);
      rst = 1'b0;
      tick(2);
      check("post_rst_c2", sif.sup_state, 3'd0);
      tick(1);
      check("post_rst_c3", sif.sup_state, 3'd1);
      relink("post_rst");
      check_counts("post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
